onehot_drain_encoder: RTL and testbench

- Inverse companion of the N-to-2^N decoder: accepts a 2^N-bit request vector (one-hot or multi-hot) and emits the binary index of every set bit, one code per handshake, lowest index first.
- Sits between request/flag aggregation logic (e.g. pending-line masks) and consumers that need binary indices, such as register-file and cache-way selects.
- Input and output each use a valid/ready handshake.
- Output code, valid and last flags are registered.

---
 rtl/onehot_drain_encoder.sv | 134 +++++++++++++
 tb/tb_onehot_drain_encoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/onehot_drain_encoder.sv
// onehot_drain_encoder
//   Accepts a 2**N-bit request vector, which may be one-hot or multi-hot.
//   Emits the binary index of every set bit, lowest index first.
//   One index is emitted per output handshake.
//   out_code, out_valid and out_last are registered.
//
// Build option:
//   ONEHOT_ENC_BACK_TO_BACK_EN - when defined, a new vector may be accepted
//   in the same cycle the final code of the current vector is taken. This
//   removes the idle cycle between vectors.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  in_vec is valid this cycle
//   in_ready  block can accept a vector
//   in_vec    request vector (2**N bits)
//   out_valid out_code holds a valid index
//   out_ready consumer takes out_code this cycle
//   out_code  binary index of the current lowest pending bit (N bits)
//   out_last  out_code is the final index of the current vector
//   zero_vec  one-cycle pulse after an all-zero vector is accepted
//   busy      a vector is being drained
module onehot_drain_encoder #(
  parameter int unsigned N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2**N-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_code,
  output logic            out_last,
  output logic            zero_vec,
  output logic            busy
);

  localparam int unsigned W = 2**N;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] pend_q,  pend_d;
  logic [N-1:0] code_q,  code_d;
  logic         last_q,  last_d;
  logic         zero_q,  zero_d;
  // Holds in_ready low until the first clock edge after reset is released.
  logic         rdy_q;

  logic         take;
  logic         accept;
  logic [W-1:0] pend_clr;

  // The loop scans from the top bit down, so the lowest set bit is
  // the last one written and wins.
  function automatic logic [N-1:0] lowest_idx(input logic [W-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int unsigned i = W; i > 0; i--) begin
      if (v[i-1]) r = N'(i-1);
    end
    return r;
  endfunction

  function automatic logic single_bit(input logic [W-1:0] v);
    return (v != '0) && ((v & (v - W'(1))) == '0);
  endfunction

  always_comb begin
    take     = (state_q == DRAIN) && out_ready;
    // Clearing the lowest set bit removes exactly the bit named by code_q.
    pend_clr = pend_q & (pend_q - W'(1));
`ifdef ONEHOT_ENC_BACK_TO_BACK_EN
    in_ready = rdy_q && ((state_q == IDLE) ||
                         ((state_q == DRAIN) && last_q && out_ready));
`else
    in_ready = rdy_q && (state_q == IDLE);
`endif
    accept   = in_valid && in_ready;

    state_d = state_q;
    pend_d  = pend_q;
    code_d  = code_q;
    last_d  = last_q;
    zero_d  = 1'b0;

    if (take) begin
      pend_d = pend_clr;
      code_d = lowest_idx(pend_clr);
      last_d = single_bit(pend_clr);
      if (last_q) state_d = IDLE;
    end

    // In the back-to-back case this overrides the return to IDLE
    // that the final take requested above.
    if (accept) begin
      zero_d = (in_vec == '0);
      if (in_vec != '0) begin
        pend_d  = in_vec;
        code_d  = lowest_idx(in_vec);
        last_d  = single_bit(in_vec);
        state_d = DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      last_q  <= last_d;
      zero_q  <= zero_d;
      rdy_q   <= 1'b1;
    end
  end

  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_code  = code_q;
  assign out_last  = last_q;
  assign zero_vec  = zero_q;

endmodule

// File: tb/tb_onehot_drain_encoder.sv
// Testbench for onehot_drain_encoder (N=4).
// The reference model keeps a queue of the indices still to be emitted.
module tb_onehot_drain_encoder;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_code;
  logic         out_last;
  logic         zero_vec;
  logic         busy;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int q[$];
  bit m_rdy  = 1'b0;
  bit m_zero = 1'b0;
`ifdef ONEHOT_ENC_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  onehot_drain_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .zero_vec  (zero_vec),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic bit model_ready(input bit ordy);
    return m_rdy && ((q.size() == 0) || (B2B && q.size() == 1 && ordy));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Applies one cycle of inputs, checks the DUT outputs,
  // advances the model at the clock edge, then returns at the next negedge.
  task automatic step(input bit rst, input bit iv, input logic [W-1:0] vec,
                      input bit ordy);
    bit  exp_rdy;
    bit  acc;
    bit  ov;
    int  tmp;
    rst_n     = rst;
    in_valid  = iv;
    in_vec    = vec;
    out_ready = ordy;
    #1;
    exp_rdy = model_ready(ordy);
    ov      = (q.size() > 0);
    chk("in_ready",  int'(in_ready),  int'(exp_rdy));
    chk("out_valid", int'(out_valid), int'(ov));
    chk("busy",      int'(busy),      int'(ov));
    chk("out_last",  int'(out_last),  int'(q.size() == 1));
    chk("zero_vec",  int'(zero_vec),  int'(m_zero));
    if (ov)         chk("out_code",       int'(out_code), q[0]);
    else if (!m_rdy) chk("out_code_reset", int'(out_code), 0);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_rdy  = 1'b0;
      m_zero = 1'b0;
    end else begin
      acc    = iv && exp_rdy;
      m_zero = acc && (vec == '0);
      if (ov && ordy) tmp = q.pop_front();
      if (acc) begin
        for (int i = 0; i < int'(W); i++)
          if (vec[i]) q.push_back(i);
      end
      m_rdy = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] v;
    int sel;
    rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    @(negedge clk);
    step(0, 0, 16'h0000, 0);
    step(0, 1, 16'h0001, 1);          // in_valid ignored in reset
    step(1, 0, 16'h0000, 0);          // in_ready still low
    // Single bit vector.
    step(1, 1, 16'h0008, 1);
    step(1, 0, 16'h0000, 1);          // code 3, out_last
    step(1, 0, 16'h0000, 1);          // back in IDLE
    // Sparse vector.
    step(1, 1, 16'h8421, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0000, 1);
    // All-ones vector with out_ready toggling.
    step(1, 1, 16'hFFFF, 1);
    for (int i = 0; i < 34; i++) step(1, 1, 16'h1234, (i % 2) == 0);
    step(1, 0, 16'h0000, 1);
    // Zero vector.
    step(1, 1, 16'h0000, 1);
    step(1, 0, 16'h0000, 1);
    step(1, 0, 16'h0000, 1);
    // Reset in the middle of a drain.
    step(1, 1, 16'h00F0, 1);
    step(1, 0, 16'h0000, 1);          // code 4 taken
    step(1, 0, 16'h0000, 1);          // code 5 taken
    step(0, 0, 16'h0000, 1);
    step(1, 0, 16'h0000, 1);
    step(1, 1, 16'h0002, 1);
    step(1, 0, 16'h0000, 1);
    step(1, 0, 16'h0000, 1);
    // Back-to-back vectors with in_valid held high.
    step(1, 1, 16'h0001, 1);
    step(1, 1, 16'h0004, 1);
    step(1, 1, 16'h0004, 1);
    step(1, 0, 16'h0000, 1);
    step(1, 0, 16'h0000, 1);
    // out_ready asserted while out_valid is low.
    step(1, 0, 16'h0000, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       v = '0;
        1:       v = '1;
        2, 3:    v = W'(1) << $urandom_range(0, W - 1);
        default: v = W'($urandom);
      endcase
      step($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, v,
           $urandom_range(0, 3) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
